// File: rtl/fpg8_uart_pkg.sv
// Shared constants and state encodings for the 16-bit word UART peripheral.
// Both the top level and the byte receiver import this package.
package fpg8_uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int BYTES_PER_WORD   = 2;

    localparam logic [2:0] TX_IDLE_ENC  = 3'd0;
    localparam logic [2:0] TX_START_ENC = 3'd1;
    localparam logic [2:0] TX_DATA_ENC  = 3'd2;
    localparam logic [2:0] TX_STOP_ENC  = 3'd3;
    localparam logic [2:0] TX_NEXT_ENC  = 3'd4;

    localparam logic [2:0] RX_IDLE_ENC  = 3'd0;
    localparam logic [2:0] RX_ARMED_ENC = 3'd1;
    localparam logic [2:0] RX_START_ENC = 3'd2;
    localparam logic [2:0] RX_DATA_ENC  = 3'd3;
    localparam logic [2:0] RX_STOP_ENC  = 3'd4;

    typedef enum logic [2:0] {
        TX_IDLE  = TX_IDLE_ENC,
        TX_START = TX_START_ENC,
        TX_DATA  = TX_DATA_ENC,
        TX_STOP  = TX_STOP_ENC,
        TX_NEXT  = TX_NEXT_ENC
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE  = RX_IDLE_ENC,
        RX_ARMED = RX_ARMED_ENC,
        RX_START = RX_START_ENC,
        RX_DATA  = RX_DATA_ENC,
        RX_STOP  = RX_STOP_ENC
    } rx_state_e;

    // Baud counter width; CLKS_PER_BIT-1 always fits in clog2(CLKS_PER_BIT) bits.
    function automatic int baud_w(input int cpb);
        return (cpb <= 2) ? 1 : $clog2(cpb);
    endfunction

endpackage

// File: rtl/uart_word_io_rx_byte.sv
// Receives one 8N1 byte: rx synchroniser, start validation, mid-bit sampling.
// Pulses byte_valid_o on the stop-bit sample; frame_err_o flags a low stop bit.
module uart_rx_byte
    import fpg8_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_ni,
    input  logic       rx_i,
    input  logic       arm_i,
    input  logic       more_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);
    localparam int            CW       = baud_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1_q, sync2_q, prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          fall;

    assign fall   = prev_q & ~sync2_q;
    assign byte_o = sh_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        sh_d         = sh_q;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        case (state_q)
            RX_IDLE: if (arm_i) state_d = RX_ARMED;
            RX_ARMED: begin
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = MID_LAST;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    // Line back high at mid-start: treat as a glitch and keep waiting.
                    if (sync2_q) begin
                        state_d = RX_ARMED;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = BIT_LAST;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    sh_d  = {sync2_q, sh_q[7:1]};
                    cnt_d = BIT_LAST;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    byte_valid_o = 1'b1;
                    frame_err_o  = ~sync2_q;
                    state_d      = more_i ? RX_ARMED : RX_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'h00;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

endmodule

// File: rtl/uart_word_io.sv
// Moves one 16-bit word over an 8N1 link as two bytes, low byte first.
// TX path is inline; RX byte framing lives in uart_rx_byte.
module uart_word_io
    import fpg8_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_receive,
    input  logic        uart_in_and_send,
    input  logic        uart_out,
    input  logic [15:0] bus_in,
    output logic [15:0] bus_out,
    output logic        uart_done,
    input  logic        rx,
    output logic        tx,
    output logic        rx_frame_err
);
    localparam int            CW        = baud_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic          LAST_BYTE = 1'(BYTES_PER_WORD - 1);

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [15:0]   tx_sh_q, tx_sh_d;
    logic          tx_byte_q, tx_byte_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          rx_idx_q, rx_idx_d;
    logic [7:0]    lo_q, lo_d;
    logic [15:0]   hold_q, hold_d;

    logic          accept_tx, accept_rx, tx_fin, rx_fin;
    logic          byte_valid, byte_ferr;
    logic [7:0]    rx_byte;

    // TX has priority when both strobes arrive in the same idle cycle.
    assign accept_tx = uart_in_and_send & ~busy_q;
    assign accept_rx = uart_receive & ~uart_in_and_send & ~busy_q;
    assign rx_fin    = byte_valid & (rx_idx_q == LAST_BYTE);

    assign tx           = (tx_state_q == TX_START || tx_state_q == TX_NEXT) ? 1'b0 :
                          (tx_state_q == TX_DATA) ? tx_sh_q[0] : 1'b1;
    assign bus_out      = uart_out ? hold_q : 16'h0000;
    assign uart_done    = done_q;
    assign rx_frame_err = ferr_q;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clk),
        .rst_ni      (reset),
        .rx_i        (rx),
        .arm_i       (accept_rx),
        .more_i      (rx_idx_q != LAST_BYTE),
        .byte_valid_o(byte_valid),
        .byte_o      (rx_byte),
        .frame_err_o (byte_ferr)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_byte_d  = tx_byte_q;
        tx_fin     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (accept_tx) begin
                    tx_state_d = TX_START;
                    tx_sh_d    = bus_in;
                    tx_cnt_d   = BIT_LAST;
                    tx_byte_d  = 1'b0;
                end
            end
            TX_START, TX_NEXT: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = BIT_LAST;
                    tx_bit_d   = 3'd0;
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            end
            TX_DATA: begin
                // After eight shifts the high byte sits in [7:0], ready for byte 1.
                if (tx_cnt_q == '0) begin
                    tx_sh_d  = {1'b0, tx_sh_q[15:1]};
                    tx_cnt_d = BIT_LAST;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    if (tx_byte_q != LAST_BYTE) begin
                        tx_state_d = TX_NEXT;
                        tx_cnt_d   = BIT_LAST;
                        tx_byte_d  = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tx_fin     = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        busy_d   = busy_q;
        done_d   = tx_fin | rx_fin;
        ferr_d   = ferr_q;
        rx_idx_d = rx_idx_q;
        lo_d     = lo_q;
        hold_d   = hold_q;
        if (accept_tx || accept_rx) busy_d = 1'b1;
        else if (tx_fin || rx_fin)  busy_d = 1'b0;
        if (accept_rx) begin
            ferr_d   = 1'b0;
            rx_idx_d = 1'b0;
        end else if (byte_valid) begin
            if (byte_ferr) ferr_d = 1'b1;
            // Holding register changes only when a full word has arrived.
            if (rx_fin) begin
                hold_d = {rx_byte, lo_q};
            end else begin
                lo_d     = rx_byte;
                rx_idx_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 16'h0000;
            tx_byte_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rx_idx_q   <= 1'b0;
            lo_q       <= 8'h00;
            hold_q     <= 16'h0000;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_byte_q  <= tx_byte_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            rx_idx_q   <= rx_idx_d;
            lo_q       <= lo_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: tb/tb_uart_word_io.sv
// Self-checking bench for uart_word_io at CLKS_PER_BIT=4: vector tables,
// hand-written corner sequences and random words against a frame-level model.
module tb_uart_word_io;
    localparam int CPB      = 4;
    localparam int DONE_CYC = 1 + 20 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        uart_receive = 1'b0;
    logic        uart_in_and_send = 1'b0;
    logic        uart_out = 1'b0;
    logic [15:0] bus_in = 16'h0000;
    logic        rx = 1'b1;
    logic [15:0] bus_out;
    logic        uart_done, tx, rx_frame_err;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [15:0] ref_hold = 16'h0000;

    typedef struct {
        logic [15:0] word;
        logic        s0;
        logic        s1;
        int          gap;
        logic [15:0] exp_word;
        logic        exp_err;
    } rx_vec_t;

    rx_vec_t     rxv[5];
    logic [15:0] txv[4];

    always #5 clk = ~clk;

    uart_word_io #(.CLKS_PER_BIT(CPB)) dut (
        .clk             (clk),
        .reset           (reset),
        .uart_receive    (uart_receive),
        .uart_in_and_send(uart_in_and_send),
        .uart_out        (uart_out),
        .bus_in          (bus_in),
        .bus_out         (bus_out),
        .uart_done       (uart_done),
        .rx              (rx),
        .tx              (tx),
        .rx_frame_err    (rx_frame_err)
    );

    always @(posedge clk) if (uart_done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_bus(input string tag);
        uart_out = 1'b1;
        #1 chk({tag, "_bus_out"}, 32'(bus_out), 32'(ref_hold));
        uart_out = 1'b0;
        #1 chk({tag, "_bus_out_gated"}, 32'(bus_out), 32'h0);
    endtask

    // Expected line: per byte a 0 start, 8 data bits LSB first, a 1 stop; each CPB cycles.
    task automatic run_tx(input string tag, input logic [15:0] w, input int poke, input logic both);
        logic       exp_bits[20];
        logic [7:0] by;
        int         bad_cyc, d0;
        logic       bad_tx, bad_done;
        for (int b = 0; b < 2; b++) begin
            by = (b == 0) ? w[7:0] : w[15:8];
            exp_bits[b*10] = 1'b0;
            for (int i = 0; i < 8; i++) exp_bits[b*10+1+i] = by[i];
            exp_bits[b*10+9] = 1'b1;
        end
        bad_cyc = -1; bad_tx = 1'b0; bad_done = 1'b0;
        d0 = done_cnt;
        @(negedge clk); bus_in = w; uart_in_and_send = 1'b1; uart_receive = both;
        @(negedge clk); uart_in_and_send = 1'b0; uart_receive = 1'b0; bus_in = 16'($urandom);
        for (int n = 1; n < DONE_CYC; n++) begin
            if (bad_cyc < 0 && (tx !== exp_bits[(n-1)/CPB] || uart_done !== 1'b0)) begin
                bad_cyc = n; bad_tx = tx; bad_done = uart_done;
            end
            uart_receive = (n == poke);
            @(negedge clk);
        end
        uart_receive = 1'b0;
        checks++;
        if (bad_cyc >= 0) begin
            errors++;
            $display("FAIL %s_wave cycle=%0d tx=%b done=%b expected tx=%b done=0",
                     tag, bad_cyc, bad_tx, bad_done, exp_bits[(bad_cyc-1)/CPB]);
        end
        chk({tag, "_done_at_81"}, 32'(uart_done), 32'h1);
        chk({tag, "_tx_idle"}, 32'(tx), 32'h1);
        tick(1);
        chk({tag, "_done_one_cycle"}, 32'(uart_done), 32'h0);
        tick(3);
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'h1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i]; tick(CPB);
        end
        rx = stop; tick(CPB);
        rx = 1'b1;
    endtask

    task automatic wait_done(input int d0);
        int waitc;
        waitc = 0;
        while (done_cnt == d0 && waitc < 30) begin
            tick(1);
            waitc++;
        end
        tick(3);
    endtask

    task automatic run_rx(input string tag, input logic [15:0] w, input logic s0, input logic s1,
                          input int gap, input logic [15:0] exp_word, input logic exp_err);
        int d0;
        @(negedge clk); uart_receive = 1'b1;
        @(negedge clk); uart_receive = 1'b0;
        chk({tag, "_ferr_cleared"}, 32'(rx_frame_err), 32'h0);
        d0 = done_cnt;
        tick(3);
        send_byte(w[7:0], s0);
        tick(gap);
        send_byte(w[15:8], s1);
        wait_done(d0);
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'h1);
        chk({tag, "_frame_err"}, 32'(rx_frame_err), 32'(exp_err));
        ref_hold = exp_word;
        check_bus(tag);
    endtask

    task automatic check_not_armed(input string tag);
        int d0;
        d0 = done_cnt;
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b1);
        tick(12);
        chk({tag, "_no_done"}, 32'(done_cnt - d0), 32'h0);
        check_bus(tag);
    endtask

    initial begin
        int          d0;
        logic [15:0] w;
        logic        s0, s1;
        int          gap;

        txv = '{16'hA53C, 16'h0000, 16'hFFFF, 16'h8001};
        rxv[0] = '{16'hAA55, 1'b0, 1'b1, 6, 16'hAA55, 1'b1};
        rxv[1] = '{16'h00FF, 1'b1, 1'b1, 0, 16'h00FF, 1'b0};
        rxv[2] = '{16'hFFFF, 1'b1, 1'b1, 3, 16'hFFFF, 1'b0};
        rxv[3] = '{16'h8001, 1'b1, 1'b0, 2, 16'h8001, 1'b1};
        rxv[4] = '{16'h0000, 1'b1, 1'b1, 1, 16'h0000, 1'b0};

        // Reset state
        uart_out = 1'b1;
        #3;
        chk("rst_tx", 32'(tx), 32'h1);
        chk("rst_done", 32'(uart_done), 32'h0);
        chk("rst_ferr", 32'(rx_frame_err), 32'h0);
        chk("rst_bus_out", 32'(bus_out), 32'h0);
        uart_out = 1'b0;
        tick(2);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) run_tx($sformatf("txv%0d", i), txv[i], 0, 1'b0);

        // Glitch while armed, then the real word 0x1234
        @(negedge clk); uart_receive = 1'b1;
        @(negedge clk); uart_receive = 1'b0;
        d0 = done_cnt;
        tick(3);
        rx = 1'b0; tick(1); rx = 1'b1;
        tick(12);
        chk("glitch_no_done", 32'(done_cnt - d0), 32'h0);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        wait_done(d0);
        chk("rx1234_done_count", 32'(done_cnt - d0), 32'h1);
        ref_hold = 16'h1234;
        check_bus("rx1234");

        check_not_armed("unarmed");

        for (int i = 0; i < 5; i++)
            run_rx($sformatf("rxv%0d", i), rxv[i].word, rxv[i].s0, rxv[i].s1,
                   rxv[i].gap, rxv[i].exp_word, rxv[i].exp_err);

        for (int i = 0; i < 4; i++) begin
            w  = 16'($urandom);
            run_tx($sformatf("rnd_tx%0d", i), w, 0, 1'b0);
            w   = 16'($urandom);
            s0  = 1'($urandom_range(0, 3) != 0);
            s1  = 1'($urandom_range(0, 3) != 0);
            gap = s0 ? $urandom_range(0, 4) : $urandom_range(2, 6);
            run_rx($sformatf("rnd_rx%0d", i), w, s0, s1, gap, w, ~(s0 & s1));
        end

        run_tx("busy_tx", 16'h3C5A, 20, 1'b0);
        check_not_armed("busy_rx_ignored");
        run_tx("both_tx", 16'h1E2D, 0, 1'b1);
        check_not_armed("both_rx_ignored");

        // Reset in the middle of a TX frame
        d0 = done_cnt;
        @(negedge clk); bus_in = 16'h00F0; uart_in_and_send = 1'b1;
        @(negedge clk); uart_in_and_send = 1'b0;
        tick(9);
        chk("midrst_tx_low_before", 32'(tx), 32'h0);
        #2 reset = 1'b0;
        #1 chk("midrst_tx_high", 32'(tx), 32'h1);
        chk("midrst_done_low", 32'(uart_done), 32'h0);
        tick(3);
        reset = 1'b1;
        tick(100);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'h0);
        ref_hold = 16'h0000;
        check_bus("midrst");
        run_tx("post_rst", 16'h5AC3, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
